vga_horizontal_sync: RTL and testbench

//   Horizontal timing generator for 640x480@60Hz VGA; upstream stage of the vertical sync generator.

---
 rtl/vga_horizontal_sync.sv | 104 ++++++++++
 tb/tb_vga_horizontal_sync.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_horizontal_sync.sv
// ---------------------------------------------------------------------------
// vga_horizontal_sync
//   Horizontal timing generator for 640x480@60Hz VGA. Walks one line of
//   TOTAL pixel ticks and produces the horizontal sync pulse, the visible
//   window flag, the current pixel index and a one-tick new_line strobe
//   that advances the vertical stage.
//
// Ports
//   clk                      system clock, everything on posedge
//   rst_n                    asynchronous reset, active-low
//   clk_25Mhz                pixel-tick enable (one clk wide, or held high)
//   horizontal_sync          SYNC_ACTIVE level while in the sync phase
//   horizontal_display_sync  1 while pixel_x is inside the visible window
//   new_line                 1 while pixel_x is the last pixel of the line
//   pixel_x[9:0]             pixel index within the line, 0..TOTAL-1
// ---------------------------------------------------------------------------
module vga_horizontal_sync #(
  parameter int   DISPLAY_TIME = 640,
  parameter int   FRONT_PROCH  = 16,
  parameter int   SYNC_TIME    = 96,
  parameter int   BACK_PROCH   = 48,
  parameter logic SYNC_ACTIVE  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_25Mhz,
  output logic       horizontal_sync,
  output logic       horizontal_display_sync,
  output logic       new_line,
  output logic [9:0] pixel_x
);

  localparam int TOTAL = DISPLAY_TIME + FRONT_PROCH + SYNC_TIME + BACK_PROCH;

  // First pixel index of each phase, and the last index of the line.
  localparam logic [9:0] FRONT_START = 10'(DISPLAY_TIME);
  localparam logic [9:0] SYNC_START  = 10'(DISPLAY_TIME + FRONT_PROCH);
  localparam logic [9:0] BACK_START  = 10'(DISPLAY_TIME + FRONT_PROCH + SYNC_TIME);
  localparam logic [9:0] LAST_X      = 10'(TOTAL - 1);

  typedef enum logic [1:0] {
    DISPLAY = 2'd0,
    FRONT   = 2'd1,
    SYNC    = 2'd2,
    BACK    = 2'd3
  } h_state_t;

  h_state_t   state;
  h_state_t   next_state;
  logic [9:0] next_x;
  logic       next_hsync;
  logic       next_display;
  logic       next_new_line;

  // Next-pixel and next-phase logic. The phase decision looks at the index
  // about to be loaded, so the registered outputs always describe the
  // registered pixel_x with no lag.
  always_comb begin
    next_x        = (pixel_x == LAST_X) ? 10'd0 : pixel_x + 10'd1;
    next_state    = state;
    next_display  = 1'b0;
    next_hsync    = ~SYNC_ACTIVE;
    next_new_line = 1'b0;

    case (state)
      DISPLAY: if (next_x == FRONT_START) next_state = FRONT;
      FRONT:   if (next_x == SYNC_START)  next_state = SYNC;
      SYNC:    if (next_x == BACK_START)  next_state = BACK;
      BACK:    if (next_x == 10'd0)       next_state = DISPLAY;
      default: next_state = DISPLAY;
    endcase

    next_display  = (next_state == DISPLAY);
    next_hsync    = (next_state == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    next_new_line = (next_x == LAST_X);
  end

  // Phase register; only advances on a pixel tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DISPLAY;
    end else if (clk_25Mhz) begin
      state <= next_state;
    end
  end

  // Pixel counter and registered outputs. Holding clk_25Mhz low freezes
  // everything, including a new_line that is already asserted, so the
  // vertical stage sees exactly one (clk_25Mhz && new_line) per line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x                 <= 10'd0;
      horizontal_sync         <= ~SYNC_ACTIVE;
      horizontal_display_sync <= 1'b1;
      new_line                <= 1'b0;
    end else if (clk_25Mhz) begin
      pixel_x                 <= next_x;
      horizontal_sync         <= next_hsync;
      horizontal_display_sync <= next_display;
      new_line                <= next_new_line;
    end
  end

endmodule

// File: tb/tb_vga_horizontal_sync.sv
// ---------------------------------------------------------------------------
// tb_vga_horizontal_sync
//   Self-checking bench for vga_horizontal_sync. A default 800-pixel instance
//   is compared against an arithmetic model of the line timing; a small
//   override instance (TOTAL=8, active-high sync) is compared against a
//   fixed table of per-pixel patterns.
// ---------------------------------------------------------------------------
module tb_vga_horizontal_sync;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_25Mhz = 1'b0;

  logic       horizontal_sync;
  logic       horizontal_display_sync;
  logic       new_line;
  logic [9:0] pixel_x;

  logic       hs8;
  logic       disp8;
  logic       nl8;
  logic [9:0] x8;

  int vectors = 0;
  int miscompares = 0;
  int ref_x = 0;

  typedef struct {
    logic [9:0] x;
    logic       disp;
    logic       hs;
    logic       nl;
  } vec_t;

  vec_t small_tab[8];

  always #5 clk = ~clk;

  vga_horizontal_sync dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .clk_25Mhz               (clk_25Mhz),
    .horizontal_sync         (horizontal_sync),
    .horizontal_display_sync (horizontal_display_sync),
    .new_line                (new_line),
    .pixel_x                 (pixel_x)
  );

  vga_horizontal_sync #(
    .DISPLAY_TIME (4),
    .FRONT_PROCH  (1),
    .SYNC_TIME    (2),
    .BACK_PROCH   (1),
    .SYNC_ACTIVE  (1'b1)
  ) dut8 (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .clk_25Mhz               (clk_25Mhz),
    .horizontal_sync         (hs8),
    .horizontal_display_sync (disp8),
    .new_line                (nl8),
    .pixel_x                 (x8)
  );

  // One clk of stimulus; the model advances when the clk carries a tick.
  // Inputs change and outputs are sampled on the falling edge.
  task automatic applyStimulus(input logic en);
    clk_25Mhz = en;
    @(posedge clk);
    if (en) ref_x = (ref_x == 799) ? 0 : ref_x + 1;
    @(negedge clk);
  endtask

  // Compare the default instance with the model: visible 0..639,
  // sync low 656..751, new_line only on pixel 799.
  task automatic checkOutput(input string name);
    logic ed, eh, en;
    ed = (ref_x < 640);
    eh = !((ref_x >= 656) && (ref_x < 752));
    en = (ref_x == 799);
    vectors++;
    if (pixel_x !== 10'(ref_x) || horizontal_display_sync !== ed ||
        horizontal_sync !== eh || new_line !== en) begin
      miscompares++;
      $display("[TB] FAIL %s: got x=%0d disp=%b hs=%b nl=%b, expected x=%0d disp=%b hs=%b nl=%b",
               name, pixel_x, horizontal_display_sync, horizontal_sync, new_line,
               ref_x, ed, eh, en);
    end
  endtask

  task automatic checkSmall(input string name, input int idx);
    vectors++;
    if (x8 !== small_tab[idx].x || disp8 !== small_tab[idx].disp ||
        hs8 !== small_tab[idx].hs || nl8 !== small_tab[idx].nl) begin
      miscompares++;
      $display("[TB] FAIL %s[%0d]: got x=%0d disp=%b hs=%b nl=%b, expected x=%0d disp=%b hs=%b nl=%b",
               name, idx, x8, disp8, hs8, nl8,
               small_tab[idx].x, small_tab[idx].disp, small_tab[idx].hs, small_tab[idx].nl);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  initial begin
    logic [7:0] p_disp;
    logic [7:0] p_hs;
    logic [7:0] p_nl;
    int disp_cnt, hs_low_cnt, nl_cnt;
    int nl_cycles[$];
    int hs_falls[$];
    logic prev_hs;
    int guard;

    // Override instance patterns, leftmost bit = pixel 0.
    p_disp = 8'b11110000;
    p_hs   = 8'b00000110;
    p_nl   = 8'b00000001;
    for (int i = 0; i < 8; i++) begin
      small_tab[i].x    = 10'(i);
      small_tab[i].disp = p_disp[7-i];
      small_tab[i].hs   = p_hs[7-i];
      small_tab[i].nl   = p_nl[7-i];
    end

    // Power-on reset.
    repeat (3) @(negedge clk);
    ref_x = 0;
    checkOutput("reset_hold");
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle, no clk edge needed.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1);
      checkOutput("pre_reset_run");
    end
    #2 rst_n = 1'b0;
    #1 ref_x = 0;
    checkOutput("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full line with one tick every fourth clk, up to pixel 799.
    disp_cnt   = horizontal_display_sync ? 1 : 0;
    hs_low_cnt = horizontal_sync ? 0 : 1;
    nl_cnt     = new_line ? 1 : 0;
    for (int k = 0; k < 799; k++) begin
      applyStimulus(1'b1);
      checkOutput("line_tick");
      if (horizontal_display_sync) disp_cnt++;
      if (!horizontal_sync) hs_low_cnt++;
      if (new_line) nl_cnt++;
      for (int j = 0; j < 3; j++) begin
        applyStimulus(1'b0);
        if (j == 2) checkOutput("line_idle");
      end
    end
    checkValue("display_pixels", disp_cnt, 640);
    checkValue("sync_pixels", hs_low_cnt, 96);
    checkValue("new_line_pixels", nl_cnt, 1);

    // Enable held low at the last pixel: new_line stays pending.
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0);
      checkOutput("gate_hold");
    end
    applyStimulus(1'b1);
    checkOutput("gate_release");

    // Continuous enable for three lines.
    prev_hs = horizontal_sync;
    for (int c = 0; c < 2400; c++) begin
      applyStimulus(1'b1);
      if (c % 97 == 0 || new_line) checkOutput("continuous");
      if (new_line) nl_cycles.push_back(c);
      if (prev_hs && !horizontal_sync) hs_falls.push_back(c);
      prev_hs = horizontal_sync;
    end
    checkValue("continuous_new_lines", nl_cycles.size(), 3);
    checkValue("continuous_hsync_falls", hs_falls.size(), 3);
    if (nl_cycles.size() == 3) begin
      checkValue("new_line_spacing_a", nl_cycles[1] - nl_cycles[0], 800);
      checkValue("new_line_spacing_b", nl_cycles[2] - nl_cycles[1], 800);
    end
    if (hs_falls.size() == 3) begin
      checkValue("hsync_period", hs_falls[2] - hs_falls[1], 800);
    end

    // Randomized enable pattern against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
      checkOutput("random");
    end

    // Random walk to pixel 700, then reset in the middle of the sync pulse.
    guard = 0;
    while (ref_x != 700 && guard < 20000) begin
      applyStimulus(($urandom_range(0, 1) != 0) ? 1'b1 : 1'b0);
      checkOutput("walk_to_700");
      guard++;
    end
    checkValue("reached_700", ref_x, 700);
    #2 rst_n = 1'b0;
    #1 ref_x = 0;
    checkOutput("reset_mid_sync");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1);
    checkOutput("post_reset_tick");

    // Override instance: three 8-pixel lines against the table.
    #2 rst_n = 1'b0;
    #1 ref_x = 0;
    checkSmall("small_reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      applyStimulus(1'b1);
      checkSmall("small_line", t % 8);
    end
    checkOutput("main_after_small");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
